rocket_tm_master: RTL and testbench

Rocket-side telemetry master for the APES count and housekeeping serial links. It generates the gate clock and active-low load strobe that the instrument FPGA's shifter consumes, and samples the returning serial data stream. It assembles MSB-first words and presents them with a valid strobe, a word index and an end-of-frame pulse. Used in the ground-support/test FPGA and in benches as the far end of each Cnt_*/Hk_* link; one instance per link.

---
 rtl/rocket_tm_pkg.sv | 24 ++
 rtl/tm_sync.sv | 21 ++
 rtl/rocket_tm_master.sv | 158 +++++++++++++++
 tb/tb_rocket_tm_master.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocket_tm_pkg.sv
// Shared definitions for the rocket-side telemetry master: link word/frame sizes
// and the master FSM state encoding.
package rocket_tm_pkg;

    localparam int WORD_BITS_DEF   = 10;
    localparam int CNT_FRAME_WORDS = 53;
    localparam int HK_FRAME_WORDS  = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        BIT_LO,
        BIT_HI,
        GAP,
        DONE
    } tm_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tm_sync.sv
// Two-flop synchronizer for a single asynchronous input bit; resets to 0.
module tm_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/rocket_tm_master.sv
// Telemetry link master: drives gtclk/invload to the instrument shifter and
// assembles the returning serial stream into MSB-first words.
module rocket_tm_master
    import rocket_tm_pkg::*;
#(
    parameter int WORD_BITS   = WORD_BITS_DEF,
    parameter int FRAME_WORDS = CNT_FRAME_WORDS,
    parameter int CLK_DIV     = 25,
    parameter int LOAD_CYCLES = 50,
    parameter int GAP_CYCLES  = 50
) (
    input  logic                           clk50,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           serial_in,
    output logic                           gtclk,
    output logic                           invload,
    output logic [WORD_BITS-1:0]           word_out,
    output logic                           word_valid,
    output logic [$clog2(FRAME_WORDS)-1:0] word_idx,
    output logic                           frame_done,
    output logic                           busy
);

    localparam int IDX_W  = $clog2(FRAME_WORDS);
    localparam int BC_W   = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam int PH_MAX = max3(CLK_DIV, LOAD_CYCLES, GAP_CYCLES);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0]  LOAD_LAST = PH_W'(LOAD_CYCLES - 1);
    localparam logic [PH_W-1:0]  DIV_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(GAP_CYCLES - 1);
    localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(WORD_BITS - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(FRAME_WORDS - 1);

    tm_state_e             state_q;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic                  phase_last;
    logic [BC_W-1:0]       bit_q;
    logic [IDX_W-1:0]      word_cnt_q;
    logic [WORD_BITS-1:0]  shift_q, shift_d;
    logic                  ser_sync;

    logic                  gtclk_q, invload_q, word_valid_q, frame_done_q, busy_q;
    logic [WORD_BITS-1:0]  word_out_q;
    logic [IDX_W-1:0]      word_idx_q;

    tm_sync u_ser_sync (
        .clk_i (clk50),
        .rst_i (rst),
        .d_i   (serial_in),
        .q_o   (ser_sync)
    );

    // Phase counter restarts on every state change and stays parked outside timed states.
    always_comb begin
        phase_last = 1'b0;
        case (state_q)
            LOAD:           phase_last = (phase_q == LOAD_LAST);
            BIT_LO, BIT_HI: phase_last = (phase_q == DIV_LAST);
            GAP:            phase_last = (phase_q == GAP_LAST);
            default:        phase_last = 1'b0;
        endcase
        phase_d = phase_q + 1'b1;
        if (phase_last || state_q == IDLE || state_q == DONE) begin
            phase_d = '0;
        end
        shift_d = {shift_q[WORD_BITS-2:0], ser_sync};
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            bit_q        <= '0;
            word_cnt_q   <= '0;
            shift_q      <= '0;
            gtclk_q      <= 1'b0;
            invload_q    <= 1'b1;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            word_idx_q   <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD;
                        invload_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        word_cnt_q <= '0;
                    end
                end
                LOAD: begin
                    if (phase_last) begin
                        state_q   <= BIT_LO;
                        invload_q <= 1'b1;
                        bit_q     <= '0;
                    end
                end
                BIT_LO: begin
                    if (phase_last) begin
                        state_q <= BIT_HI;
                        gtclk_q <= 1'b1;
                        shift_q <= shift_d;
                    end
                end
                BIT_HI: begin
                    if (phase_last) begin
                        gtclk_q <= 1'b0;
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            // Publish during the first GAP cycle; shift_q already holds all bits.
                            state_q      <= GAP;
                            word_out_q   <= shift_q;
                            word_idx_q   <= word_cnt_q;
                            word_valid_q <= 1'b1;
                            frame_done_q <= (word_cnt_q == WORD_LAST);
                        end else begin
                            state_q <= BIT_LO;
                        end
                    end
                end
                GAP: begin
                    if (phase_last) begin
                        if (word_cnt_q == WORD_LAST) begin
                            state_q <= DONE;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                            state_q    <= LOAD;
                            invload_q  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gtclk      = gtclk_q;
    assign invload    = invload_q;
    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign word_idx   = word_idx_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rocket_tm_master.sv
// Directed bench: counts-link master (default timing) and a fast housekeeping-style
// master, each looped back through a behavioral instrument shifter.
module tb_rocket_tm_master;

    logic clk50 = 1'b0;
    always #10 clk50 = ~clk50;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: default parameters
    logic       rst_a = 1'b1, start_a = 1'b0, ser_a;
    logic       gtclk_a, invload_a, wv_a, fd_a, busy_a;
    logic [9:0] wo_a;
    logic [5:0] wi_a;

    // Instance B: fast timing, 10-word frames
    logic       rst_b = 1'b1, start_b = 1'b0, ser_b;
    logic       gtclk_b, invload_b, wv_b, fd_b, busy_b;
    logic [9:0] wo_b;
    logic [3:0] wi_b;

    rocket_tm_master #(
        .WORD_BITS(10), .FRAME_WORDS(53), .CLK_DIV(25), .LOAD_CYCLES(50), .GAP_CYCLES(50)
    ) u_dut_a (
        .clk50(clk50), .rst(rst_a), .start(start_a), .serial_in(ser_a),
        .gtclk(gtclk_a), .invload(invload_a), .word_out(wo_a), .word_valid(wv_a),
        .word_idx(wi_a), .frame_done(fd_a), .busy(busy_a)
    );

    rocket_tm_master #(
        .WORD_BITS(10), .FRAME_WORDS(10), .CLK_DIV(4), .LOAD_CYCLES(4), .GAP_CYCLES(1)
    ) u_dut_b (
        .clk50(clk50), .rst(rst_b), .start(start_b), .serial_in(ser_b),
        .gtclk(gtclk_b), .invload(invload_b), .word_out(wo_b), .word_valid(wv_b),
        .word_idx(wi_b), .frame_done(fd_b), .busy(busy_b)
    );

    // Instrument shifters: 2-flop sync of gtclk/invload, parallel load while invload
    // is low, shift left one cycle after a synchronized gtclk rise, MSB on the line.
    logic [9:0] mem_a [0:255];
    logic [9:0] mem_b [0:255];
    logic [2:0] gs_a, ls_a, gs_b, ls_b;
    logic [9:0] sh_a, sh_b;
    logic [7:0] widx_a, widx_b;

    always_ff @(posedge clk50 or posedge rst_a) begin
        if (rst_a) begin
            gs_a <= '0; ls_a <= '1; sh_a <= '0; widx_a <= '0;
        end else begin
            gs_a <= {gs_a[1:0], gtclk_a};
            ls_a <= {ls_a[1:0], invload_a};
            if (!ls_a[1]) sh_a <= mem_a[widx_a];
            else if (gs_a[1] && !gs_a[2]) sh_a <= {sh_a[8:0], 1'b0};
            if (ls_a[1] && !ls_a[2]) widx_a <= widx_a + 8'd1;
        end
    end
    assign ser_a = sh_a[9];

    always_ff @(posedge clk50 or posedge rst_b) begin
        if (rst_b) begin
            gs_b <= '0; ls_b <= '1; sh_b <= '0; widx_b <= '0;
        end else begin
            gs_b <= {gs_b[1:0], gtclk_b};
            ls_b <= {ls_b[1:0], invload_b};
            if (!ls_b[1]) sh_b <= mem_b[widx_b];
            else if (gs_b[1] && !gs_b[2]) sh_b <= {sh_b[8:0], 1'b0};
            if (ls_b[1] && !ls_b[2]) widx_b <= widx_b + 8'd1;
        end
    end
    assign ser_b = sh_b[9];

    // Output recorders, sampled on the falling edge
    logic [9:0] qw_a[$], qw_b[$];
    int         qi_a[$], qi_b[$];
    bit         qf_a[$], qf_b[$];
    int rises_a = 0, rises_b = 0, busyc_a = 0, busyc_b = 0, fdc_a = 0, fdc_b = 0;
    logic gprev_a = 1'b0, gprev_b = 1'b0;

    always @(negedge clk50) begin
        if (wv_a === 1'b1) begin
            qw_a.push_back(wo_a); qi_a.push_back(int'(wi_a)); qf_a.push_back(fd_a);
        end
        if (fd_a === 1'b1) fdc_a++;
        if (gtclk_a === 1'b1 && gprev_a === 1'b0) rises_a++;
        gprev_a = gtclk_a;
        if (busy_a === 1'b1) busyc_a++;
        if (wv_b === 1'b1) begin
            qw_b.push_back(wo_b); qi_b.push_back(int'(wi_b)); qf_b.push_back(fd_b);
        end
        if (fd_b === 1'b1) fdc_b++;
        if (gtclk_b === 1'b1 && gprev_b === 1'b0) rises_b++;
        gprev_b = gtclk_b;
        if (busy_b === 1'b1) busyc_b++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse(input bit sel);
        @(negedge clk50);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk50);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input bit sel, input int maxc, input string tag);
        int c;
        c = 0;
        while (((sel ? busy_b : busy_a) === 1'b1) && c < maxc) begin
            @(negedge clk50);
            c++;
        end
        chk({tag, "_idle_in_time"}, 32'(c < maxc), 32'd1);
    endtask

    task automatic reset_b();
        @(negedge clk50);
        rst_b = 1'b1;
        @(negedge clk50);
        @(negedge clk50);
        rst_b = 1'b0;
        @(negedge clk50);
    endtask

    task automatic chk_frame_b(input string tag, input int qb, input int mb);
        chk({tag, "_nwords"}, 32'(qw_b.size() - qb), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (qb + k < qw_b.size()) begin
                chk($sformatf("%s_word%0d", tag, k), 32'(qw_b[qb+k]), 32'(mem_b[8'(mb+k)]));
                chk($sformatf("%s_idx%0d", tag, k), 32'(qi_b[qb+k]), 32'(k));
                chk($sformatf("%s_fd%0d", tag, k), 32'(qf_b[qb+k]), 32'(k == 9));
            end
        end
    endtask

    initial begin
        int qb, rb, bb, fb, c;

        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 10'(k + 'h100);
            mem_b[k] = 10'((k * 'h5B) ^ 'h2A5);
        end
        mem_b[0] = 10'h2AA;
        mem_b[1] = 10'h3FF;
        mem_b[2] = 10'h001;

        repeat (3) @(negedge clk50);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk50);
        chk("rst_gtclk",   32'(gtclk_b),   32'd0);
        chk("rst_invload", 32'(invload_b), 32'd1);
        chk("rst_busy",    32'(busy_b),    32'd0);
        chk("rst_wout",    32'(wo_b),      32'd0);
        chk("rst_wvalid",  32'(wv_b),      32'd0);
        chk("rst_widx",    32'(wi_b),      32'd0);
        chk("rst_fdone",   32'(fd_b),      32'd0);
        chk("rst_a_busy",  32'(busy_a),    32'd0);
        chk("rst_a_inv",   32'(invload_a), 32'd1);

        // Counts-link frame at default timing
        qb = qw_a.size(); rb = rises_a; bb = busyc_a; fb = fdc_a;
        @(negedge clk50);
        start_a = 1'b1;
        chk("a_inv_before_edge", 32'(invload_a), 32'd1);
        @(negedge clk50);
        start_a = 1'b0;
        chk("a_inv_after_start", 32'(invload_a), 32'd0);
        chk("a_busy_after_start", 32'(busy_a), 32'd1);
        wait_idle(1'b0, 33000, "a_frame");
        chk("a_nwords", 32'(qw_a.size() - qb), 32'd53);
        for (int k = 0; k < 53; k++) begin
            if (qb + k < qw_a.size()) begin
                chk($sformatf("a_word%0d", k), 32'(qw_a[qb+k]), 32'(k + 'h100));
                chk($sformatf("a_idx%0d", k), 32'(qi_a[qb+k]), 32'(k));
            end
        end
        chk("a_fd_count", 32'(fdc_a - fb), 32'd1);
        chk("a_fd_last", 32'(qf_a[$]), 32'd1);
        chk("a_rises", 32'(rises_a - rb), 32'd530);
        chk("a_busy_cycles", 32'(busyc_a - bb), 32'd31801);

        // Bit order: 0x2AA, 0x3FF, 0x001 lead the frame
        reset_b();
        qb = qw_b.size(); rb = rises_b; bb = busyc_b;
        pulse(1'b1);
        wait_idle(1'b1, 2000, "bitorder");
        chk_frame_b("bitorder", qb, 0);
        chk("bitorder_rises", 32'(rises_b - rb), 32'd100);
        chk("bitorder_busy", 32'(busyc_b - bb), 32'd851);

        // Asynchronous reset while gtclk is high, after a frame left word_out nonzero
        pulse(1'b1);
        c = 0;
        while (gtclk_b !== 1'b1 && c < 100) begin
            @(negedge clk50);
            c++;
        end
        chk("arst_reached_hi", 32'(gtclk_b), 32'd1);
        #3 rst_b = 1'b1;
        #1;
        chk("arst_gtclk",   32'(gtclk_b),   32'd0);
        chk("arst_invload", 32'(invload_b), 32'd1);
        chk("arst_busy",    32'(busy_b),    32'd0);
        chk("arst_wout",    32'(wo_b),      32'd0);
        chk("arst_widx",    32'(wi_b),      32'd0);
        chk("arst_wvalid",  32'(wv_b),      32'd0);
        @(negedge clk50);
        @(negedge clk50);
        rst_b = 1'b0;

        // Start pulses at 10 (accepted), 300 (busy) and in the DONE cycle (861)
        @(negedge clk50);
        qb = qw_b.size(); rb = rises_b; bb = busyc_b; fb = fdc_b;
        for (int i = 0; i <= 900; i++) begin
            @(negedge clk50);
            if (i == 861) chk("ign_busy_in_done", 32'(busy_b), 32'd1);
            if (i == 862) chk("ign_idle_after_done", 32'(busy_b), 32'd0);
            start_b = (i == 10 || i == 300 || i == 861);
        end
        start_b = 1'b0;
        chk("ign_busy_end", 32'(busy_b), 32'd0);
        chk("ign_nwords", 32'(qw_b.size() - qb), 32'd10);
        chk("ign_rises", 32'(rises_b - rb), 32'd100);
        chk("ign_busy_cycles", 32'(busyc_b - bb), 32'd851);
        chk("ign_fd_count", 32'(fdc_b - fb), 32'd1);
        qb = qw_b.size();
        pulse(1'b1);
        wait_idle(1'b1, 2000, "second");
        chk_frame_b("second", qb, 10);

        // Reset during BIT_HI of word 5
        reset_b();
        qb = qw_b.size();
        pulse(1'b1);
        c = 0;
        while (qw_b.size() < qb + 5 && c < 1000) begin
            @(negedge clk50);
            c++;
        end
        chk("mid_five_words", 32'(qw_b.size() - qb), 32'd5);
        c = 0;
        while (gtclk_b !== 1'b1 && c < 100) begin
            @(negedge clk50);
            c++;
        end
        chk("mid_in_bit_hi", 32'(gtclk_b), 32'd1);
        chk("mid_last_idx", 32'(qi_b[$]), 32'd4);
        #3 rst_b = 1'b1;
        @(negedge clk50);
        @(negedge clk50);
        rst_b = 1'b0;
        repeat (200) @(negedge clk50);
        chk("mid_no_more_words", 32'(qw_b.size() - qb), 32'd5);
        chk("mid_idle", 32'(busy_b), 32'd0);
        qb = qw_b.size();
        pulse(1'b1);
        wait_idle(1'b1, 2000, "after_rst");
        chk_frame_b("after_rst", qb, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
